// File: rtl/debug_uart_sink.sv
// Avalon-MM debug UART sink: CPU writes bytes into a FIFO that drains
// out of an 8N1 serial transmitter.
//
// Ports:
//   clk, rstn       - system clock, asynchronous active-low reset
//   avs_address     - 0 = DATA (write pushes a byte), 1 = STATUS
//   avs_write       - write strobe, avs_writedata[7:0] is the byte
//   avs_read        - read strobe (reads have no side effects)
//   avs_readdata    - DATA reads 0; STATUS = {count[12:4], busy, empty, full}
//   avs_waitrequest - stalls a DATA write while the FIFO is full
//   uart_txd        - serial output, idle high
//   tx_busy         - high while a frame is on the line
module debug_uart_sink #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;

  logic full, empty, push, pop;
  logic baud_last;
  logic [8:0]  cnt9;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = ^{avs_read, avs_writedata[31:8]};

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = avs_write & ~avs_address & ~full;

  assign avs_waitrequest = avs_write & ~avs_address & full;

  assign cnt9   = 9'(cnt_q);
  assign status = {19'd0, cnt9, 1'b0, tx_busy, empty, full};

  assign avs_readdata = avs_address ? status : 32'd0;

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_busy   = (state_q != IDLE);
  assign uart_txd  = txd_q;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= avs_writedata[7:0];
  end

  // Transmit FSM
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state so txd is glitch free
  // and lines up with the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_debug_uart_sink.sv
// Bench for debug_uart_sink: register vectors from a table plus
// directed serial-frame sequences decoded by a line monitor.
module tb_debug_uart_sink;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        avs_address = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        uart_txd;
  logic        tx_busy;

  debug_uart_sink #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .uart_txd(uart_txd),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_total = 0;
  logic [7:0] rxq[$];
  int starts[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_busy) busy_total <= busy_total + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Line monitor: decodes 8N1 frames sampled mid-bit.
  initial begin
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_txd) begin
        starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        chk("start_bit", 32'(uart_txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", 32'(uart_txd), 32'd1);
        rxq.push_back(b);
      end
      prev = uart_txd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_bus();
    avs_write = 1'b0;
    avs_read = 1'b0;
    avs_address = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] d, output int stalls);
    avs_address = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b1;
    avs_writedata = {24'hA5A5A5, d};
    stalls = 0;
    #2;
    while (avs_waitrequest && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(output logic [31:0] v);
    avs_write = 1'b0;
    avs_address = 1'b1;
    avs_read = 1'b1;
    #2;
    v = avs_readdata;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rxq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 32'(rxq.size()), 32'(n));
  endtask

  typedef struct {
    logic        addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_wait;
    logic        exp_txd;
    logic        exp_busy;
  } vec_t;

  vec_t tv[7];

  initial begin
    logic [31:0] v;
    int st, sum, b0, maxc;
    string hello;
    logic [7:0] six[6];
    int stall[6];

    tv[0] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h2,  1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0,  1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b0, 32'hFF,        32'h2,  1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h2,  1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFF41,  32'h0,  1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h10, 1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h6,  1'b0, 1'b0, 1'b1};

    // Reset state
    idle_bus();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    avs_write = 1'b1;
    #1;
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    avs_write = 1'b0;
    avs_address = 1'b1;
    #1;
    chk("rst_status", avs_readdata, 32'h2);
    idle_bus();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Register vectors, ending in a single 0x41 push
    b0 = busy_total;
    for (int i = 0; i < 7; i++) begin
      avs_address = tv[i].addr;
      avs_write = tv[i].wr;
      avs_read = tv[i].rd;
      avs_writedata = tv[i].wdata;
      #2;
      chk($sformatf("vec%0d_rd", i), avs_readdata, tv[i].exp_rd);
      chk($sformatf("vec%0d_wait", i), 32'(avs_waitrequest),
          32'(tv[i].exp_wait));
      chk($sformatf("vec%0d_txd", i), 32'(uart_txd), 32'(tv[i].exp_txd));
      chk($sformatf("vec%0d_busy", i), 32'(tx_busy), 32'(tv[i].exp_busy));
      @(posedge clk);
      #1;
    end
    idle_bus();
    wait_rx(1, 100, "a_frames");
    cycles(5);
    chk("a_byte", 32'(rxq[0]), 32'h41);
    chk("a_busy_cycles", 32'(busy_total - b0), 32'd40);

    // "Hello" back to back
    rxq.delete();
    starts.delete();
    hello = "Hello";
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      bus_write(hello[i], st);
      sum += st;
    end
    idle_bus();
    chk("hello_stalls", 32'(sum), 32'd0);
    wait_rx(5, 300, "hello_frames");
    for (int i = 0; i < 5; i++)
      chk($sformatf("hello_ch%0d", i), 32'(rxq[i]), 32'(hello[i]));
    for (int i = 1; i < 5; i++)
      chk($sformatf("hello_gap%0d", i), 32'(starts[i] - starts[i-1]),
          32'd41);
    cycles(10);

    // Six bytes into a four-deep FIFO
    rxq.delete();
    six = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    for (int i = 0; i < 6; i++) bus_write(six[i], stall[i]);
    read_status(v);
    chk("six_full_status", v, 32'h45);
    idle_bus();
    for (int i = 0; i < 5; i++)
      chk($sformatf("six_stall%0d", i), 32'(stall[i]), 32'd0);
    chk("six_stall5", 32'(stall[5]), 32'd38);
    maxc = int'(v[12:4]);
    for (int k = 0; k < 400 && v != 32'h2; k++) begin
      read_status(v);
      if (int'(v[12:4]) > maxc) maxc = int'(v[12:4]);
    end
    chk("six_max_count", 32'(maxc), 32'd4);
    wait_rx(6, 100, "six_frames");
    for (int i = 0; i < 6; i++)
      chk($sformatf("six_byte%0d", i), 32'(rxq[i]), 32'(six[i]));
    cycles(5);

    // Push in the same cycle the last byte pops
    rxq.delete();
    bus_write(8'hC3, st);
    bus_write(8'h3C, st);
    read_status(v);
    idle_bus();
    chk("same_cycle_status", v, 32'h14);
    wait_rx(2, 150, "same_frames");
    chk("same_byte0", 32'(rxq[0]), 32'hC3);
    chk("same_byte1", 32'(rxq[1]), 32'h3C);
    cycles(5);

    // Reset in the middle of bit 3 with three bytes queued
    bus_write(8'h55, st);
    bus_write(8'h11, st);
    bus_write(8'h22, st);
    bus_write(8'h33, st);
    idle_bus();
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_bit3", 32'(uart_txd), 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(uart_txd), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    avs_address = 1'b1;
    #1;
    chk("rst_mid_status", avs_readdata, 32'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    avs_address = 1'b0;
    cycles(60);
    rxq.delete();
    cycles(150);
    chk("rst_no_frames", 32'(rxq.size()), 32'd0);
    read_status(v);
    chk("rst_after_status", v, 32'h2);
    idle_bus();

    // First push right after reset release
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    avs_address = 1'b0;
    avs_write = 1'b1;
    avs_writedata = 32'h5A;
    #1;
    chk("rel_wait", 32'(avs_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    read_status(v);
    chk("rel_status", v, 32'h10);
    wait_rx(1, 100, "rel_frames");
    chk("rel_byte", 32'(rxq[0]), 32'h5A);
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_uart_sink.md
DEBUG_UART_SINK -- requirements
Module: debug_uart_sink

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set UART bit period in clk cycles (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set character FIFO depth; power of two, 2..256.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 avs_address  input  1  word offset: 0 = DATA, 1 = STATUS.
REQ-006 avs_write  input  1  Avalon-MM write strobe.
REQ-007 avs_writedata  input  32  write data; only [7:0] SHALL be used.
REQ-008 avs_read  input  1  Avalon-MM read strobe.
REQ-009 avs_readdata  output  32  read data, combinational from avs_address.
REQ-010 avs_waitrequest  output  1  stall to the bus master.
REQ-011 uart_txd  output  1  serial 8N1 output, idle high.
REQ-012 tx_busy  output  1  high while any frame is being shifted out.

Function
REQ-013 Block SHALL be the slave decoded at CPU data address 0x1000000; a write to DATA pushes writedata[7:0] into the FIFO.
REQ-014 avs_waitrequest SHALL be high exactly when avs_write=1, avs_address=0 and the FIFO is full; the write SHALL complete, with no byte dropped, on the first cycle the FIFO is not full.
REQ-015 Reads and STATUS writes SHALL never assert avs_waitrequest; STATUS writes SHALL be ignored.
REQ-016 STATUS readdata: bit0 = full, bit1 = empty, bit2 = tx_busy, bits[12:4] = FIFO count (0..FIFO_DEPTH), all other bits 0.
REQ-017 DATA readdata SHALL be 0.
REQ-018 FIFO SHALL be circular, with read and write pointers wrapping modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-019 If a push and a pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 IDLE: uart_txd=1; if the FIFO is non-empty at the clock edge, pop the head byte into the shift register and go to START.
REQ-022 START: uart_txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-023 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, tracked by a 3-bit bit counter; after bit 7 go to STOP.
REQ-024 STOP: uart_txd=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-025 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-026 Back-to-back frames SHALL have exactly 1 idle-high cycle between a STOP end and the next START.
REQ-027 tx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-028 A byte pushed into an empty FIFO while in IDLE SHALL make uart_txd fall 2 cycles after the write cycle: push edge, then pop edge.
REQ-029 The baud counter SHALL be 16 bits, reload to 0 on every state or bit change, and never free-run in IDLE.

Reset
REQ-030 When rstn is low, the block SHALL asynchronously force: FIFO pointers and count = 0, FSM = IDLE, baud and bit counters = 0, uart_txd = 1, tx_busy = 0.
REQ-031 After reset, STATUS SHALL read 0x00000002 (empty) and avs_waitrequest SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame, discard FIFO contents and drive uart_txd high immediately, without waiting for clk.
REQ-033 After rstn deasserts, the first valid push SHALL be accepted on the first clk edge.

Verification
REQ-034 Reset release, read STATUS -> 0x00000002; uart_txd=1; tx_busy=0.
REQ-035 CLKS_PER_BIT=4, write 0x41 to DATA -> uart_txd falls 2 cycles later; bench samples 0,1,0,0,0,0,0,1,0,1 at 4-cycle spacing; tx_busy high for 40 cycles.
REQ-036 CLKS_PER_BIT=4, write "Hello" (5 bytes) back-to-back -> no waitrequest; decoded output "Hello"; 41-cycle spacing between START edges.
REQ-037 FIFO_DEPTH=4, CLKS_PER_BIT=4, write 6 bytes with no gaps -> waitrequest asserts on the 6th write until the first frame pops a slot; all 6 bytes emitted in order; STATUS count never exceeds 4.
REQ-038 Assert rstn low at bit 3 of a frame with 3 bytes queued -> uart_txd=1 with no clk edge; STATUS=0x00000002 after release; no further frames emitted.
REQ-039 Push at the cycle the FIFO pops its last byte -> count stays 1; that byte is sent as the next frame.
